// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit encodings, field positions and framing states
package noc_pkg;

  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  localparam int FLIT_ID_MSB = 31;
  localparam int FLIT_ID_LSB = 29;
  localparam int DST_MSB     = 3;
  localparam int DST_LSB     = 0;
  localparam int SRC_MSB     = 7;
  localparam int SRC_LSB     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/noc_pkt_checker.sv
// rtl/noc_pkt_checker.sv - write-side packet framing checker with sticky proto_err
module noc_pkt_checker
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_fire,
  input  logic [2:0] wr_flit_id,
  output logic       proto_err
);

  pkt_state_t state;

  // A stray HEADER inside a packet is flagged but still opens the new packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      proto_err <= 1'b0;
    end else if (wr_fire) begin
      case (wr_flit_id)
        HEADER: begin
          if (state == PKT) proto_err <= 1'b1;
          state <= PKT;
        end
        BODY: begin
          if (state == IDLE) proto_err <= 1'b1;
        end
        TAIL: begin
          if (state == IDLE) proto_err <= 1'b1;
          else               state     <= IDLE;
        end
        default: proto_err <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_fifo.sv
// rtl/noc_input_fifo.sv - credit-flow-controlled router input flit buffer
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] flit_in,
  input  logic                  read_en,
  output logic                  credit_out,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  overflow_err,
  output logic                  proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [PTR_W:0]        count_next;
  logic                  rd_fire;
  logic                  wr_fire;

  assign rd_fire = read_en & ~empty;
  assign wr_fire = valid_in & (~full | rd_fire);

  always_comb begin
    count_next = count;
    case ({wr_fire, rd_fire})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is deliberately left out of reset; empty gates its visibility.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      empty      <= (count_next == '0);
      full       <= (count_next == FULL_CNT);
      credit_out <= rd_fire;
      if (valid_in & full & ~rd_fire) overflow_err <= 1'b1;
    end
  end

  assign flit_out = mem[rd_ptr];
  assign flit_id  = flit_out[FLIT_ID_MSB:FLIT_ID_LSB];
  assign dst_addr = flit_out[DST_MSB:DST_LSB];

  noc_pkt_checker u_pkt_checker (
    .clk        (clk),
    .rst        (rst),
    .wr_fire    (wr_fire),
    .wr_flit_id (flit_in[FLIT_ID_MSB:FLIT_ID_LSB]),
    .proto_err  (proto_err)
  );

endmodule
